// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: 32-bit atan(2^-i) table, turn constants and FSM states.
// Define CORDIC_GAIN_COMP_EN to add the COMP state and the 1/K shift-add constant.
package cordic_pkg;

  localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;
  localparam logic [31:0] HALF_TURN    = 32'h8000_0000;

`ifdef CORDIC_GAIN_COMP_EN
  // 1/K ~= 0.607253 as 39797 / 2^16; each set bit is one shifted add of x
  localparam int          INV_GAIN_FRAC  = 16;
  localparam logic [15:0] INV_GAIN_TERMS = 16'h9B75;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
`ifdef CORDIC_GAIN_COMP_EN
    COMP   = 2'd2,
`endif
    DONE   = 2'd3
  } cordic_state_t;

  // Rescales a 32-bit turn fraction (2^32 = 360 deg) to a narrower angle width
  function automatic logic [63:0] scale_turn(input logic [31:0] t, input int width);
    return ({32'd0, t} << width) >> 32;
  endfunction

  function automatic logic [31:0] atan_lookup(input int idx);
    logic [31:0] a;
    case (idx)
      0:  a = 32'h2000_0000;
      1:  a = 32'h12E4_051E;
      2:  a = 32'h09FB_385B;
      3:  a = 32'h0511_11D4;
      4:  a = 32'h028B_0D43;
      5:  a = 32'h0145_D7E1;
      6:  a = 32'h00A2_F61E;
      7:  a = 32'h0051_7C55;
      8:  a = 32'h0028_BE53;
      9:  a = 32'h0014_5F2F;
      10: a = 32'h000A_2F98;
      11: a = 32'h0005_17CC;
      12: a = 32'h0002_8BE6;
      13: a = 32'h0001_45F3;
      14: a = 32'h0000_A2FA;
      15: a = 32'h0000_517D;
      16: a = 32'h0000_28BE;
      17: a = 32'h0000_145F;
      18: a = 32'h0000_0A30;
      19: a = 32'h0000_0518;
      20: a = 32'h0000_028C;
      21: a = 32'h0000_0146;
      22: a = 32'h0000_00A3;
      23: a = 32'h0000_0051;
      24: a = 32'h0000_0029;
      25: a = 32'h0000_0014;
      26: a = 32'h0000_000A;
      27: a = 32'h0000_0005;
      28: a = 32'h0000_0003;
      29: a = 32'h0000_0001;
      30: a = 32'h0000_0001;
      default: a = 32'h0000_0000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Handshake and data bundle for the vectoring CORDIC: input vector side and result side.
interface cordic_vectoring_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  Xin;
  logic signed [DATA_WIDTH-1:0]  Yin;
  logic                          out_valid;
  logic                          out_ready;
  logic        [DATA_WIDTH:0]    mag;
  logic signed [ANGLE_WIDTH-1:0] phase;

  modport master (
    output in_valid, Xin, Yin, out_ready,
    input  in_ready, out_valid, mag, phase
  );

  modport slave (
    input  in_valid, Xin, Yin, out_ready,
    output in_ready, out_valid, mag, phase
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// atan(2^-i) lookup scaled to ANGLE_WIDTH; shared by the rotation and vectoring CORDICs.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter  int ANGLE_WIDTH = 32,
  parameter  int ITER        = 16,
  localparam int IDX_W       = (ITER > 1) ? $clog2(ITER) : 1
) (
  input  logic [IDX_W-1:0]       index,
  output logic [ANGLE_WIDTH-1:0] angle
);

  always_comb begin
    angle = ANGLE_WIDTH'(scale_turn(atan_lookup(int'(index)), ANGLE_WIDTH));
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (Xin, Yin) -> magnitude and atan2 phase, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to scale mag by 1/K in an extra COMP cycle.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 32,
  parameter int ITER        = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  cordic_vectoring_if.slave  bus
);

  localparam int XW    = DATA_WIDTH + 2;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [ANGLE_WIDTH-1:0] Z_POS =
    ANGLE_WIDTH'(scale_turn(QUARTER_TURN, ANGLE_WIDTH));
  localparam logic [ANGLE_WIDTH-1:0] Z_NEG =
    ANGLE_WIDTH'(scale_turn(HALF_TURN + QUARTER_TURN, ANGLE_WIDTH));

  cordic_state_t state_q, state_d;

  logic signed [XW-1:0]    x_q, y_q, x_d, y_d, x_sh, y_sh;
  logic signed [XW-1:0]    xin_w, yin_w, pre_x, pre_y;
  logic [ANGLE_WIDTH-1:0]  z_q, z_d, pre_z, atan_i;
  logic [CNT_W-1:0]        iter_q;
  logic                    zero_q;
  logic                    last_iter;
  logic [DATA_WIDTH:0]     mag_q;
  logic [ANGLE_WIDTH-1:0]  phase_q;

  cordic_atan_rom #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ITER        (ITER)
  ) u_atan_rom (
    .index (iter_q),
    .angle (atan_i)
  );

  assign xin_w     = {{2{bus.Xin[DATA_WIDTH-1]}}, bus.Xin};
  assign yin_w     = {{2{bus.Yin[DATA_WIDTH-1]}}, bus.Yin};
  assign last_iter = (iter_q == CNT_W'(ITER - 1));
  assign bus.mag   = mag_q;
  assign bus.phase = phase_q;

  // Left-half-plane vectors are turned by +/-90 deg so x starts non-negative
  always_comb begin
    pre_x = xin_w;
    pre_y = yin_w;
    pre_z = '0;
    if (bus.Xin[DATA_WIDTH-1]) begin
      if (!bus.Yin[DATA_WIDTH-1]) begin
        pre_x = yin_w;
        pre_y = -xin_w;
        pre_z = Z_POS;
      end else begin
        pre_x = -yin_w;
        pre_y = xin_w;
        pre_z = Z_NEG;
      end
    end
  end

  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (!y_q[XW-1]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_i;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_i;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  logic [XW+INV_GAIN_FRAC-1:0] gain_prod;
  logic [DATA_WIDTH:0]         comp_mag;

  always_comb begin
    gain_prod = '0;
    for (int b = 0; b < INV_GAIN_FRAC; b++) begin
      if (INV_GAIN_TERMS[b]) begin
        gain_prod = gain_prod + ({{INV_GAIN_FRAC{1'b0}}, x_q} << b);
      end
    end
    gain_prod = gain_prod + ((XW+INV_GAIN_FRAC)'(1) << (INV_GAIN_FRAC - 1));
    comp_mag  = (DATA_WIDTH+1)'(gain_prod >> INV_GAIN_FRAC);
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = ROTATE;
      end
      ROTATE: begin
`ifdef CORDIC_GAIN_COMP_EN
        if (last_iter) state_d = COMP;
`else
        if (last_iter) state_d = DONE;
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      COMP: state_d = DONE;
`endif
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Results are only written on the final cycle, so mag/phase stay frozen through DONE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q    <= pre_x;
            y_q    <= pre_y;
            z_q    <= pre_z;
            iter_q <= '0;
            zero_q <= (bus.Xin == '0) && (bus.Yin == '0);
          end
        end
        ROTATE: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + CNT_W'(1);
`ifndef CORDIC_GAIN_COMP_EN
          if (last_iter) begin
            mag_q   <= zero_q ? '0 : x_d[DATA_WIDTH:0];
            phase_q <= zero_q ? '0 : z_d;
          end
`endif
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          mag_q   <= zero_q ? '0 : comp_mag;
          phase_q <= zero_q ? '0 : z_q;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
